// File: rtl/rom_stream_pkg.sv
// Shared types and helpers for the ROM stream reader slice.
// Holds the sequencer state encoding and a constant ceil-log2 helper.
package rom_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rom_stream_fifo.sv
// Small synchronous FIFO buffering ROM words (data plus last flag).
// Storage is reset so the read port shows zero after reset.
module rom_stream_fifo
    import rom_stream_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        push_data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        pop_data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [clog2(DEPTH):0]   count_o
);

    localparam int PW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic [PW:0]      count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == (PW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rom_stream_reader.sv
// Walks a ROM address window, buffers the returned words in a FIFO and
// streams them out on valid/ready with an end-of-burst marker.
module rom_stream_reader
    import rom_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 4,
    parameter int ROM_DEPTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  rom_rd_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int CW = clog2(FIFO_DEPTH) + 1;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  inflight_q;
    logic                  inflight_last_q;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [DATA_WIDTH:0]   fifo_rd_data;
    logic [CW:0]           credit_used;
    logic                  issue;
    logic                  pop;
    logic                  final_issue;

    // A read may issue only if its word is guaranteed a FIFO slot on arrival.
    assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign issue       = (state_q == ISSUE) && !fifo_full &&
                         (credit_used < (CW+1)'(FIFO_DEPTH));
    assign final_issue = (remaining_q == (ADDR_WIDTH+1)'(1));
    assign addr_d      = (addr_q == ADDR_WIDTH'(ROM_DEPTH - 1)) ? '0
                                                                : addr_q + ADDR_WIDTH'(1);
    assign pop         = out_valid && out_ready;

    assign busy      = busy_q;
    assign done      = done_q;
    assign rom_rd_en = issue;
    assign rom_addr  = addr_q;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rd_data[DATA_WIDTH-1:0];
    assign out_last  = fifo_rd_data[DATA_WIDTH] && !fifo_empty;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= issue;
            inflight_last_q <= issue && final_issue;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q      <= start_addr;
                        remaining_q <= length;
                        if (length == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr_q      <= addr_d;
                        remaining_q <= remaining_q - (ADDR_WIDTH+1)'(1);
                        if (final_issue) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    rom_stream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_b       (rst_b),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, rom_data}),
        .pop_i       (pop),
        .pop_data_o  (fifo_rd_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Sequencer/consumer sitting directly in front of a generated synchronous ROM (1-cycle registered read, rd_en/addr in, data_out out).
- On a start command it walks a contiguous address window, drives the ROM read port, captures the returned words into a small FIFO, and presents them on a valid/ready stream with an end-of-burst marker.
- Rate-decouples the fixed-latency ROM from a back-pressuring downstream consumer without losing or duplicating words.

Parameters:
- DATA_WIDTH, 9, ROM word width.
- ADDR_WIDTH, 4, ROM address width.
- ROM_DEPTH, 16, number of ROM words; addresses wrap modulo ROM_DEPTH.
- FIFO_DEPTH, 4, output buffer entries (power of two, >= 2).

Ports:
- clk  input  1  clock.
- rst_b  input  1  asynchronous active-low reset.
- start  input  1  one-cycle command pulse; sampled only in IDLE.
- start_addr  input  ADDR_WIDTH  first ROM address of the burst.
- length  input  ADDR_WIDTH+1  number of words, 0..ROM_DEPTH.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when the burst completes.
- rom_rd_en  output  1  ROM read enable.
- rom_addr  output  ADDR_WIDTH  ROM address.
- rom_data  input  DATA_WIDTH  ROM data_out, valid the cycle after rom_rd_en.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready.
- out_data  output  DATA_WIDTH  stream word.
- out_last  output  1  high with the final word of the burst.

Behaviour:
- Interface: one clock `clk`; reset `rst_b` is asynchronous and active-low.
- Reset values:
  - busy=0, done=0, rom_rd_en=0, rom_addr=0, out_valid=0, out_last=0, out_data=0.
  - FIFO empty, FSM in IDLE.
  - Reset asserted mid-burst drops all in-flight and buffered words. No done pulse is generated.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: start=1 latches start_addr and length, sets busy the next cycle.
    - length=0: go straight to a one-cycle done pulse with no ROM reads; stay in IDLE.
    - Otherwise go to ISSUE.
  - ISSUE: assert rom_rd_en with rom_addr = current address when credit is available.
    - Credit: FIFO occupancy + reads in flight (0 or 1) < FIFO_DEPTH.
    - Each issue increments the address (wraps ROM_DEPTH-1 -> 0) and decrements the remaining-issue count.
    - When the last read is issued, go to DRAIN.
  - DRAIN: wait until all words have been accepted downstream.
    - The cycle after the final out_valid&&out_ready, pulse done=1 and drop busy.
    - Return to IDLE.
- Read pipeline:
  - A registered in-flight flag tracks the 1-cycle ROM latency.
  - rom_data is written into the FIFO the cycle after rom_rd_en, unconditionally; credit guarantees space.
  - Peak throughput is one word per cycle when out_ready is held high.
  - Latency from start to first out_valid is 3 cycles: start -> ISSUE register -> ROM read -> FIFO write visible.
- Stream:
  - out_data and out_last are stable while out_valid=1 and out_ready=0.
  - A word transfers on out_valid&&out_ready.
  - out_last is tagged at FIFO write for the word from the final issued read.
- Simultaneous FIFO push and pop in one cycle: occupancy unchanged, both operations honoured.
- FIFO full: issue stalls; never overflows.
- FIFO empty: out_valid=0.
- start while busy=1 is ignored; no queuing.
- length=ROM_DEPTH reads every word exactly once, starting at start_addr and wrapping.
- rom_rd_en is never asserted outside ISSUE.

Decomposition:
- Shared package rom_stream_pkg holds:
  - state enum type (IDLE/ISSUE/DRAIN);
  - helper function for ceil-log2 of FIFO_DEPTH.
- One natural sub-module: rom_stream_fifo, a synchronous FIFO of width DATA_WIDTH+1 (data + last) and depth FIFO_DEPTH, exposing full, empty and count.

Test Plan:
- start_addr=0, length=16, out_ready=1 constant:
  - 16 words 0x000..0x00F, one per cycle after a 3-cycle initial latency;
  - out_last only on 0x00F;
  - done pulses exactly once, the cycle after the last transfer.
- start_addr=14, length=4:
  - rom_addr sequence 14, 15, 0, 1;
  - output 0x00E, 0x00F, 0x000, 0x001 with out_last on 0x001.
- length=0:
  - no rom_rd_en ever asserted;
  - done pulses one cycle after start;
  - out_valid stays 0.
- start_addr=3, length=8, out_ready held 0 for 10 cycles, then 1:
  - exactly FIFO_DEPTH=4 reads issued, then issue stalls;
  - after release, words 0x003..0x00A arrive in order with no loss or duplication;
  - data stable while stalled.
- Random out_ready toggling, length=16:
  - output sequence is exactly the 16 words in order, one out_last;
  - a second start pulsed mid-burst has no effect.
- rst_b asserted mid-burst (after 5 words):
  - all outputs return to reset values immediately;
  - a new start afterwards produces a clean burst.
